// File: rtl/ycc_pkg.sv
// Shared constants, types and arithmetic helpers for the RGB -> YCbCr converter.
// Coefficients are BT.601 full-range values scaled by 256.
package ycc_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned COEF_W = 9;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned SHIFT  = 8;

    localparam logic signed [ACC_W-1:0] ROUND_C = 18'sd128;
    localparam logic signed [ACC_W-1:0] PIX_MAX = 18'sd255;

    localparam logic signed [COEF_W-1:0] Y_R  =  9'sd77;
    localparam logic signed [COEF_W-1:0] Y_G  =  9'sd150;
    localparam logic signed [COEF_W-1:0] Y_B  =  9'sd29;
    localparam logic signed [COEF_W-1:0] CB_R = -9'sd43;
    localparam logic signed [COEF_W-1:0] CB_G = -9'sd85;
    localparam logic signed [COEF_W-1:0] CB_B =  9'sd128;
    localparam logic signed [COEF_W-1:0] CR_R =  9'sd128;
    localparam logic signed [COEF_W-1:0] CR_G = -9'sd107;
    localparam logic signed [COEF_W-1:0] CR_B = -9'sd21;

    // Frame/line flags carried alongside each pixel.
    typedef struct packed {
        logic sof;
        logic eol;
    } sideband_t;

    // One clamped 8-bit channel result plus whether the clamp engaged.
    typedef struct packed {
        logic             clamp;
        logic [PIX_W-1:0] data;
    } sat_pix_t;

    // Signed coefficient times unsigned pixel, in the accumulator width.
    function automatic logic signed [ACC_W-1:0] coef_mul(
        input logic signed [COEF_W-1:0] c,
        input logic        [PIX_W-1:0]  x
    );
        logic signed [ACC_W-1:0] c_ext;
        logic signed [ACC_W-1:0] x_ext;
        c_ext = ACC_W'(c);
        x_ext = $signed(ACC_W'(x));
        return c_ext * x_ext;
    endfunction

    function automatic sat_pix_t clamp_u8(input logic signed [ACC_W-1:0] v);
        sat_pix_t res;
        if (v[ACC_W-1]) begin
            res.clamp = 1'b1;
            res.data  = '0;
        end else if (v > PIX_MAX) begin
            res.clamp = 1'b1;
            res.data  = '1;
        end else begin
            res.clamp = 1'b0;
            res.data  = v[PIX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/ycc_chan_mac.sv
// One output channel: S1 three products, S2 sum, S3 round/shift/offset/clamp.
// The clamp flag of the S3 stage is exported unregistered so the top can register it.
module ycc_chan_mac
    import ycc_pkg::*;
#(
    parameter logic signed [COEF_W-1:0] C0     = '0,
    parameter logic signed [COEF_W-1:0] C1     = '0,
    parameter logic signed [COEF_W-1:0] C2     = '0,
    parameter int                       OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [PIX_W-1:0] x0,
    input  logic [PIX_W-1:0] x1,
    input  logic [PIX_W-1:0] x2,
    output logic [PIX_W-1:0] data,
    output logic             clamp_c
);

    logic signed [ACC_W-1:0] prod0, prod1, prod2;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] biased;
    sat_pix_t                clamped;

    // Arithmetic shift gives floor rounding on negative sums.
    always_comb begin
        shifted = (sum_q + ROUND_C) >>> SHIFT;
        biased  = shifted + ACC_W'(OFFSET);
        clamped = clamp_u8(biased);
        clamp_c = clamped.clamp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod0 <= '0;
            prod1 <= '0;
            prod2 <= '0;
            sum_q <= '0;
            data  <= '0;
        end else if (!hold) begin
            prod0 <= coef_mul(C0, x0);
            prod1 <= coef_mul(C1, x1);
            prod2 <= coef_mul(C2, x2);
            sum_q <= prod0 + prod1 + prod2;
            data  <= clamped.data;
        end
    end

endmodule

// File: rtl/rgb_to_ycbcr_pipe.sv
// Three-stage pipelined RGB to YCbCr (BT.601 full range) converter with a
// global hold, carrying valid/sof/eol alongside the pixel data.
module rgb_to_ycbcr_pipe
    import ycc_pkg::*;
#(
    parameter int CB_OFFSET = 128,
    parameter int CR_OFFSET = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [PIX_W-1:0] r_ch,
    input  logic [PIX_W-1:0] g_ch,
    input  logic [PIX_W-1:0] b_ch,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [PIX_W-1:0] luma_ch,
    output logic [PIX_W-1:0] cb_ch,
    output logic [PIX_W-1:0] cr_ch,
    output logic             sat
);

    logic      v1, v2;
    sideband_t sb1, sb2;
    logic      y_clamp_c, cb_clamp_c, cr_clamp_c;

    ycc_chan_mac #(.C0(Y_R),  .C1(Y_G),  .C2(Y_B),  .OFFSET(0)) u_luma (
        .clk(clk), .rst(rst), .hold(hold),
        .x0(r_ch), .x1(g_ch), .x2(b_ch),
        .data(luma_ch), .clamp_c(y_clamp_c)
    );

    ycc_chan_mac #(.C0(CB_R), .C1(CB_G), .C2(CB_B), .OFFSET(CB_OFFSET)) u_cb (
        .clk(clk), .rst(rst), .hold(hold),
        .x0(r_ch), .x1(g_ch), .x2(b_ch),
        .data(cb_ch), .clamp_c(cb_clamp_c)
    );

    ycc_chan_mac #(.C0(CR_R), .C1(CR_G), .C2(CR_B), .OFFSET(CR_OFFSET)) u_cr (
        .clk(clk), .rst(rst), .hold(hold),
        .x0(r_ch), .x1(g_ch), .x2(b_ch),
        .data(cr_ch), .clamp_c(cr_clamp_c)
    );

    // Flag pipeline matches the three data stages; flags are gated off on bubbles.
    // Luma has only positive coefficients and never clamps, so OR-ing it into sat is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            sb1       <= '0;
            sb2       <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            sat       <= 1'b0;
        end else if (!hold) begin
            v1        <= in_valid;
            sb1.sof   <= in_sof;
            sb1.eol   <= in_eol;
            v2        <= v1;
            sb2       <= sb1;
            out_valid <= v2;
            out_sof   <= v2 & sb2.sof;
            out_eol   <= v2 & sb2.eol;
            sat       <= y_clamp_c | cb_clamp_c | cr_clamp_c;
        end
    end

endmodule

// File: tb/tb_rgb_to_ycbcr_pipe.sv
// Scoreboard bench for rgb_to_ycbcr_pipe with hand-computed BT.601 vectors.
module tb_rgb_to_ycbcr_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_eol = 1'b0;
    logic [7:0] r_ch = '0;
    logic [7:0] g_ch = '0;
    logic [7:0] b_ch = '0;
    logic       out_valid, out_sof, out_eol, sat;
    logic [7:0] luma_ch, cb_ch, cr_ch;

    rgb_to_ycbcr_pipe dut (
        .clk(clk), .rst(rst), .hold(hold),
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
        .r_ch(r_ch), .g_ch(g_ch), .b_ch(b_ch),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
        .luma_ch(luma_ch), .cb_ch(cb_ch), .cr_ch(cr_ch), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y, cb, cr;
        logic       sat, sof, eol;
        int         tag;
    } exp_t;

    exp_t        q[$];
    int          en_cnt = 0;
    bit          adv_last = 1'b0;
    bit          rst_last = 1'b0;
    bit          snap_ok = 1'b0;
    logic [27:0] snap = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Enabled-edge bookkeeping: latency is measured in non-hold, non-reset edges.
    always @(posedge clk) begin
        adv_last <= !hold && !rst;
        rst_last <= rst;
        if (!hold && !rst) en_cnt <= en_cnt + 1;
    end

    // Monitor: pops one expectation per newly presented output pixel.
    always @(negedge clk) begin
        exp_t e;
        if (rst_last) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_sof", 32'(out_sof), 0);
            chk("rst_out_eol", 32'(out_eol), 0);
            chk("rst_sat", 32'(sat), 0);
            chk("rst_luma", 32'(luma_ch), 0);
            chk("rst_cb", 32'(cb_ch), 0);
            chk("rst_cr", 32'(cr_ch), 0);
        end else begin
            if (!out_valid) begin
                chk("bubble_sof", 32'(out_sof), 0);
                chk("bubble_eol", 32'(out_eol), 0);
            end
            if (adv_last) begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got Y=%0d Cb=%0d Cr=%0d, expected no pixel (t=%0t)",
                                 luma_ch, cb_ch, cr_ch, $time);
                    end else begin
                        e = q.pop_front();
                        chk("luma", 32'(luma_ch), 32'(e.y));
                        chk("cb", 32'(cb_ch), 32'(e.cb));
                        chk("cr", 32'(cr_ch), 32'(e.cr));
                        chk("sat", 32'(sat), 32'(e.sat));
                        chk("out_sof", 32'(out_sof), 32'(e.sof));
                        chk("out_eol", 32'(out_eol), 32'(e.eol));
                        chk("latency_edge", en_cnt - 1, e.tag + 2);
                    end
                end
            end else if (snap_ok) begin
                chk("hold_frozen", 32'({out_valid, out_sof, out_eol, sat, luma_ch, cb_ch, cr_ch}), 32'(snap));
            end
        end
        snap    <= {out_valid, out_sof, out_eol, sat, luma_ch, cb_ch, cr_ch};
        snap_ok <= 1'b1;
    end

    task automatic send(input logic [7:0] r, g, b, input logic sof, eol,
                        input logic [7:0] y, cb, cr, input logic s);
        rst = 1'b0; hold = 1'b0; in_valid = 1'b1;
        r_ch = r; g_ch = g; b_ch = b; in_sof = sof; in_eol = eol;
        q.push_back('{y: y, cb: cb, cr: cr, sat: s, sof: sof, eol: eol, tag: en_cnt});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic sof);
        hold = 1'b0; in_valid = 1'b0; in_sof = sof; in_eol = sof;
        r_ch = 8'd33; g_ch = 8'd66; b_ch = 8'd99;
        repeat (n) @(negedge clk);
        in_sof = 1'b0; in_eol = 1'b0;
    endtask

    // Inputs during hold carry a junk pixel that must not be captured.
    task automatic hold_cycles(input int n);
        hold = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_eol = 1'b1;
        r_ch = 8'hAA; g_ch = 8'h55; b_ch = 8'hAA;
        repeat (n) @(negedge clk);
        hold = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
        q.delete();
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0; hold = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b0);

        // Black and white
        send(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128, 1'b0);
        drain("drain_black");
        send(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 8'd255, 8'd128, 8'd128, 1'b0);
        drain("drain_white");

        // Primaries back to back, sof on red, eol on blue
        send(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, 8'd77, 8'd85, 8'd255, 1'b1);
        send(8'd0, 8'd255, 8'd0, 1'b0, 1'b0, 8'd149, 8'd43, 8'd21, 1'b0);
        send(8'd0, 8'd0, 8'd255, 1'b0, 1'b1, 8'd29, 8'd255, 8'd107, 1'b1);
        drain("drain_primaries");

        // Five-pixel stream with holds (second hold lands while out_valid is high)
        send(8'd100, 8'd150, 8'd200, 1'b1, 1'b0, 8'd141, 8'd161, 8'd99, 1'b0);
        send(8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 8'd18, 8'd135, 8'd122, 1'b0);
        hold_cycles(4);
        send(8'd200, 8'd100, 8'd50, 1'b0, 1'b0, 8'd124, 8'd86, 8'd182, 1'b0);
        send(8'd0, 8'd0, 8'd200, 1'b0, 1'b0, 8'd23, 8'd228, 8'd112, 1'b0);
        hold_cycles(2);
        send(8'd50, 8'd200, 8'd0, 1'b0, 1'b1, 8'd132, 8'd53, 8'd69, 1'b0);
        drain("drain_hold_stream");

        // Reset with two pixels in flight
        send(8'd100, 8'd150, 8'd200, 1'b0, 1'b0, 8'd141, 8'd161, 8'd99, 1'b0);
        send(8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 8'd18, 8'd135, 8'd122, 1'b0);
        do_reset(1);
        send(8'd200, 8'd100, 8'd50, 1'b0, 1'b0, 8'd124, 8'd86, 8'd182, 1'b0);
        drain("drain_after_reset");

        // Alternating valid with sof/eol raised on bubble cycles
        send(8'd0, 8'd0, 8'd200, 1'b0, 1'b0, 8'd23, 8'd228, 8'd112, 1'b0);
        idle(1, 1'b1);
        send(8'd50, 8'd200, 8'd0, 1'b0, 1'b0, 8'd132, 8'd53, 8'd69, 1'b0);
        idle(1, 1'b1);
        send(8'd100, 8'd150, 8'd200, 1'b0, 1'b0, 8'd141, 8'd161, 8'd99, 1'b0);
        idle(1, 1'b1);
        drain("drain_bubbles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
